// File: rtl/clkdiv_ctrl_if.sv
// Ratio configuration port of the clock divider controller: a valid/ready
// offer of a new half-period plus the illegal-ratio error pulse.
interface clkdiv_ctrl_if #(
  parameter int CNT_W = 8
) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Run/stop and ratio controller for the fabric clock divider. New ratios are
// held pending and only take effect at a clk_out falling boundary or in STOP.
module clkdiv_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  clkdiv_ctrl_if.slave     cfg,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] pend_div;
  logic             pend_valid;
  logic             clk_nxt;
  logic             tick_nxt;
  logic             apply;
  logic             term;
  logic             accept;
  logic             err_q;

  // cur_div is never 0, so the terminal compare cannot wrap
  assign term          = (cnt == (cur_div - CNT_W'(1)));
  assign accept        = cfg.cfg_valid & ~pend_valid;
  assign cfg.cfg_ready = ~pend_valid;
  assign cfg.cfg_err   = err_q;
  assign busy          = (state != STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clk_nxt   = clk_out;
    tick_nxt  = 1'b0;
    apply     = 1'b0;
    case (state)
      STOP: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        apply   = pend_valid;
        if (run_req) state_nxt = RUN;
      end
      RUN: begin
        if (!run_req && !clk_out) begin
          // Stopping in the low phase simply truncates it
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else if (term) begin
          cnt_nxt  = '0;
          clk_nxt  = ~clk_out;
          tick_nxt = 1'b1;
          if (clk_out) begin
            apply = pend_valid;
            if (!run_req) state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (!run_req) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (term) begin
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
          tick_nxt  = 1'b1;
          apply     = pend_valid;
          state_nxt = run_req ? RUN : STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (run_req) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = STOP;
        cnt_nxt   = '0;
        clk_nxt   = 1'b0;
      end
    endcase
  end

  // Accept and apply are exclusive: accepting needs an empty pending slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      err_q      <= 1'b0;
      cur_div    <= CNT_W'(DEF_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
      err_q   <= accept && (cfg.cfg_div == '0);
      if (apply) begin
        cur_div    <= pend_div;
        pend_valid <= 1'b0;
      end else if (accept && (cfg.cfg_div != '0)) begin
        pend_div   <= cfg.cfg_div;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed and randomized checks of clkdiv_ctrl against a phase-countdown
// reference model of the divided clock and its pending-ratio slot.
module tb_clkdiv_ctrl;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run_req = 1'b0;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: phase level, cycles left in the phase, ratio, pending slot
  int m_n, m_pend, m_left;
  bit m_busy, m_level, m_tick, m_err;

  clkdiv_ctrl_if #(.CNT_W(CNT_W)) cfg_bus ();

  clkdiv_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .run_req (run_req),
    .cfg     (cfg_bus),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = DEF_DIV; m_pend = -1; m_left = 0;
    m_busy = 0; m_level = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input int d);
    bit acc;
    acc   = v && (m_pend < 0);
    m_err = acc && (d == 0);
    if (!m_busy) begin
      m_tick = 0; m_level = 0;
      if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; end
      if (r) begin m_busy = 1; m_left = m_n; end
    end else if (!r && !m_level) begin
      m_busy = 0; m_tick = 0;
    end else if (m_left == 1) begin
      m_level = !m_level; m_tick = 1;
      if (!m_level) begin
        if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; end
        if (!r) m_busy = 0;
      end
      m_left = m_n;
    end else begin
      m_left--; m_tick = 0;
    end
    if (acc && d != 0) m_pend = d;
  endtask

  task automatic check_all();
    check_output("clk_out", clk_out, m_level);
    check_output("tick", tick, m_tick);
    check_output("busy", busy, m_busy);
    check_output("cur_div", cur_div, m_n);
    check_output("cfg_ready", cfg_bus.cfg_ready, m_pend < 0);
    check_output("cfg_err", cfg_bus.cfg_err, m_err);
  endtask

  task automatic apply_stimulus(input bit r, input bit v, input int d);
    run_req           = r;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_div   = CNT_W'(d);
    model_step(r, v, d);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic wait_clk_out(input bit r, input logic lvl, input string tag);
    int i;
    i = 0;
    while (clk_out !== lvl && i < 64) begin
      apply_stimulus(r, 1'b0, 0);
      i++;
    end
    check_output(tag, clk_out === lvl, 1);
  endtask

  initial begin
    int t0, r1, r2, hi, guard;
    bit rr;
    model_reset();
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_div   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    apply_stimulus(0, 0, 0);

    $display("[TB] default ratio start-up");
    apply_stimulus(1, 0, 0);
    t0 = cyc;
    wait_clk_out(1, 1'b1, "t1_rise");
    check_output("t1_first_rise", cyc - t0, 4);
    r1 = cyc;
    wait_clk_out(1, 1'b0, "t1_fall");
    wait_clk_out(1, 1'b1, "t1_rise2");
    r2 = cyc;
    check_output("t1_period", r2 - r1, 8);

    $display("[TB] ratio change during high phase");
    apply_stimulus(1, 1, 2);
    check_output("t2_ready_low", cfg_bus.cfg_ready, 0);
    check_output("t2_div_held", cur_div, 4);
    wait_clk_out(1, 1'b0, "t2_fall");
    check_output("t2_div_new", cur_div, 2);
    wait_clk_out(1, 1'b1, "t2_rise");
    hi = 0;
    while (clk_out === 1'b1 && hi < 64) begin hi++; apply_stimulus(1, 0, 0); end
    check_output("t2_high_len", hi, 2);

    $display("[TB] illegal ratio");
    apply_stimulus(1, 1, 0);
    check_output("t3_err", cfg_bus.cfg_err, 1);
    check_output("t3_ready", cfg_bus.cfg_ready, 1);
    apply_stimulus(1, 0, 0);
    check_output("t3_err_clear", cfg_bus.cfg_err, 0);
    check_output("t3_div", cur_div, 2);

    $display("[TB] stop in high and low phase");
    apply_stimulus(1, 1, 3);
    wait_clk_out(1, 1'b1, "t4_rise_a");
    wait_clk_out(1, 1'b0, "t4_fall_a");
    wait_clk_out(1, 1'b1, "t4_rise_b");
    hi = 0;
    while (clk_out === 1'b1 && hi < 64) begin hi++; apply_stimulus(0, 0, 0); end
    check_output("t4_drain_len", hi, 3);
    check_output("t4_busy_high", busy, 0);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    check_output("t4_busy_low", busy, 0);
    check_output("t4_clk_low", clk_out, 0);

    $display("[TB] divide by one");
    apply_stimulus(0, 1, 1);
    apply_stimulus(0, 0, 0);
    check_output("t5_div_stop", cur_div, 1);
    apply_stimulus(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1, 0, 0);
      check_output("t5_tick", tick, 1);
    end
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 0);

    $display("[TB] randomized run");
    rr = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) rr = !rr;
      apply_stimulus(rr, $urandom_range(0, 3) == 0, int'($urandom_range(0, 6)));
    end

    $display("[TB] reset with pending config");
    guard = 0;
    while ((busy !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) && guard < 1000) begin
      apply_stimulus(0, 0, 0);
      guard++;
    end
    check_output("t6_idle", busy === 1'b0 && cfg_bus.cfg_ready === 1'b1, 1);
    apply_stimulus(0, 1, 5);
    apply_stimulus(0, 0, 0);
    apply_stimulus(1, 0, 0);
    wait_clk_out(1, 1'b1, "t6_rise");
    apply_stimulus(1, 1, 7);
    check_output("t6_pending", cfg_bus.cfg_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check_output("t6_clk_out", clk_out, 0);
    check_output("t6_div", cur_div, DEF_DIV);
    check_output("t6_ready", cfg_bus.cfg_ready, 1);
    check_output("t6_busy", busy, 0);
    check_output("t6_tick", tick, 0);
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0);
    for (int i = 0; i < 12; i++) apply_stimulus(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
